// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, stall/flush control and mult/div busy tracking
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  E_dst,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        D_null_req,
  output logic        F_pc_en,
  output logic        FD_en,
  output logic        FD_null_slot,
  output logic        DE_clear,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CLOG_W  = $clog2(MAX_CYC + 1);
  localparam int CNT_W   = (CLOG_W < 4) ? 4 : CLOG_W;

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             rs_hazard, rt_hazard, md_hazard, stall;

  // A source stalls only when a producer in E/M will not have its result ready in time.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    src_hazard = (src != 5'd0) &&
                 (((src == e_dst) && (e_tnew > tuse)) ||
                  ((src == m_dst) && (m_tnew > tuse)));
  endfunction

  always_comb begin
    rs_hazard = src_hazard(D_rs, D_rs_tuse, E_dst, E_tnew, M_dst, M_tnew);
    rt_hazard = src_hazard(D_rt, D_rt_tuse, E_dst, E_tnew, M_dst, M_tnew);
    md_busy   = (md_cnt_q != '0);
    md_hazard = D_is_md && (md_busy || E_md_start);
    stall     = rs_hazard || rt_hazard || md_hazard;
  end

  // A null request arriving while stalled is dropped, not held for later.
  always_comb begin
    F_pc_en      = 1'b1;
    FD_en        = 1'b1;
    DE_clear     = 1'b0;
    FD_null_slot = D_null_req;
    if (stall) begin
      F_pc_en      = 1'b0;
      FD_en        = 1'b0;
      DE_clear     = 1'b1;
      FD_null_slot = 1'b0;
    end
  end

  // Starts issued while the unit is still counting are ignored.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end else if (E_md_start) begin
      md_cnt_d = E_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
